// File: rtl/dshot_command_controller_if.sv
// Decoded-frame bus from the DShot input/processing stage to the command controller.
interface dshot_command_controller_if;
  logic        frame_strobe;
  logic [10:0] set_speed;
  logic [5:0]  special_command;
  logic        is_special_command;
  logic        crc_valid;
  logic        telemetry_bit;

  modport master (
    output frame_strobe, set_speed, special_command,
           is_special_command, crc_valid, telemetry_bit
  );

  modport slave (
    input  frame_strobe, set_speed, special_command,
           is_special_command, crc_valid, telemetry_bit
  );
endinterface

// File: rtl/dshot_command_controller.sv
// DShot command controller: arming, throttle hand-off, failsafe timeout and special commands.
// Optional bad-CRC frame counter enabled by defining DSHOT_CRC_ERR_COUNT_EN.
module dshot_command_controller #(
  parameter int unsigned CLK_HZ         = 16000000,
  parameter int unsigned TIMEOUT_CYCLES = 1600000,
  parameter int unsigned ARM_FRAMES     = 10,
  parameter int unsigned CMD_REPEAT     = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  dshot_command_controller_if.slave  frame_if,
  output logic [10:0]                throttle,
  output logic                       throttle_valid,
  output logic                       armed,
  output logic                       failsafe,
  output logic                       direction,
  output logic [5:0]                 cmd_out,
  output logic                       cmd_strobe,
  output logic                       telemetry_req,
  output logic [7:0]                 crc_err_count
);

  localparam int unsigned AW = $clog2(ARM_FRAMES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(CMD_REPEAT + 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_FRAMES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(CMD_REPEAT);

  if (CLK_HZ == 0 || TIMEOUT_CYCLES < 1 || ARM_FRAMES < 1 || CMD_REPEAT < 1) begin : g_param_check
    $error("dshot_command_controller: invalid parameter value");
  end

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FAILSAFE = 2'd2
  } state_e;

  state_e        state_q;
  logic [10:0]   throttle_q;
  logic          throttle_valid_q;
  logic          armed_q;
  logic          failsafe_q;
  logic          direction_q;
  logic [5:0]    cmd_out_q;
  logic          cmd_strobe_q;
  logic          telemetry_req_q;
  logic [AW-1:0] arm_cnt_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [5:0]    last_cmd_q;
  logic          last_is_cmd_q;

  logic good, is_cmd, cmd0, same_cmd, eligible, rep_hit, fire;

  always_comb begin
    good     = frame_if.frame_strobe && frame_if.crc_valid;
    is_cmd   = frame_if.is_special_command;
    cmd0     = is_cmd && (frame_if.special_command == 6'd0);
    same_cmd = is_cmd && last_is_cmd_q && (frame_if.special_command == last_cmd_q);
    rep_cnt_d = '0;
    if (is_cmd) begin
      if (!same_cmd)                rep_cnt_d = RW'(1);
      else if (rep_cnt_q != REP_MAX) rep_cnt_d = rep_cnt_q + RW'(1);
      else                          rep_cnt_d = rep_cnt_q;
    end
    // A count already saturated means this run of repeats has fired once.
    rep_hit  = (rep_cnt_d == REP_MAX) && !(same_cmd && (rep_cnt_q == REP_MAX));
    eligible = (state_q == DISARMED) || ((state_q == ARMED) && (throttle_q == '0));
    fire     = 1'b0;
    if (good && is_cmd && eligible) begin
      if (frame_if.special_command >= 6'd1 && frame_if.special_command <= 6'd5)
        fire = 1'b1;
      else if (frame_if.special_command >= 6'd7 && frame_if.special_command <= 6'd21)
        fire = rep_hit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= DISARMED;
      throttle_q       <= '0;
      throttle_valid_q <= 1'b0;
      armed_q          <= 1'b0;
      failsafe_q       <= 1'b0;
      direction_q      <= 1'b0;
      cmd_out_q        <= '0;
      cmd_strobe_q     <= 1'b0;
      telemetry_req_q  <= 1'b0;
      arm_cnt_q        <= '0;
      timer_q          <= '0;
      rep_cnt_q        <= '0;
      last_cmd_q       <= '0;
      last_is_cmd_q    <= 1'b0;
    end else begin
      cmd_strobe_q    <= fire;
      telemetry_req_q <= good && frame_if.telemetry_bit;

      if (good) begin
        rep_cnt_q     <= rep_cnt_d;
        last_cmd_q    <= frame_if.special_command;
        last_is_cmd_q <= is_cmd;
      end

      if (fire) begin
        cmd_out_q <= frame_if.special_command;
        case (frame_if.special_command)
          6'd7, 6'd20: direction_q <= 1'b0;
          6'd8, 6'd21: direction_q <= 1'b1;
          default:     direction_q <= direction_q;
        endcase
      end

      case (state_q)
        DISARMED: begin
          throttle_q <= '0;
          if (good) begin
            if (!cmd0) begin
              arm_cnt_q <= '0;
            end else if (arm_cnt_q == ARM_LAST) begin
              state_q          <= ARMED;
              armed_q          <= 1'b1;
              throttle_valid_q <= 1'b1;
              arm_cnt_q        <= '0;
              timer_q          <= '0;
            end else begin
              arm_cnt_q <= arm_cnt_q + AW'(1);
            end
          end
        end
        ARMED: begin
          // A good frame landing on the expiry cycle reloads the timer and keeps ARMED.
          if (good) begin
            timer_q    <= '0;
            throttle_q <= is_cmd ? 11'd0 : frame_if.set_speed;
          end else if (timer_q == TO_LAST) begin
            state_q          <= FAILSAFE;
            armed_q          <= 1'b0;
            failsafe_q       <= 1'b1;
            throttle_valid_q <= 1'b0;
            throttle_q       <= '0;
            timer_q          <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        FAILSAFE: begin
          throttle_q <= '0;
          if (good && cmd0) begin
            state_q    <= DISARMED;
            failsafe_q <= 1'b0;
            arm_cnt_q  <= AW'(1);
          end
        end
        default: begin
          state_q          <= DISARMED;
          armed_q          <= 1'b0;
          failsafe_q       <= 1'b0;
          throttle_valid_q <= 1'b0;
          throttle_q       <= '0;
        end
      endcase
    end
  end

`ifdef DSHOT_CRC_ERR_COUNT_EN
  logic [7:0] crc_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      crc_err_q <= '0;
    else if (frame_if.frame_strobe && !frame_if.crc_valid && crc_err_q != 8'hFF)
      crc_err_q <= crc_err_q + 8'd1;
  end

  assign crc_err_count = crc_err_q;
`else
  assign crc_err_count = '0;
`endif

  assign throttle       = throttle_q;
  assign throttle_valid = throttle_valid_q;
  assign armed          = armed_q;
  assign failsafe       = failsafe_q;
  assign direction      = direction_q;
  assign cmd_out        = cmd_out_q;
  assign cmd_strobe     = cmd_strobe_q;
  assign telemetry_req  = telemetry_req_q;

endmodule

// File: tb/tb_dshot_command_controller.sv
// Directed self-checking bench for dshot_command_controller (short timeout for simulation).
module tb_dshot_command_controller;

`ifdef DSHOT_CRC_ERR_COUNT_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [10:0] throttle;
  logic        throttle_valid, armed, failsafe, direction, cmd_strobe, telemetry_req;
  logic [5:0]  cmd_out;
  logic [7:0]  crc_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  dshot_command_controller_if fi ();

  dshot_command_controller #(
    .CLK_HZ        (16000000),
    .TIMEOUT_CYCLES(50),
    .ARM_FRAMES    (10),
    .CMD_REPEAT    (6)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_if      (fi),
    .throttle      (throttle),
    .throttle_valid(throttle_valid),
    .armed         (armed),
    .failsafe      (failsafe),
    .direction     (direction),
    .cmd_out       (cmd_out),
    .cmd_strobe    (cmd_strobe),
    .telemetry_req (telemetry_req),
    .crc_err_count (crc_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic is_cmd, input logic [10:0] speed, input logic [5:0] cmd,
                      input logic crc, input logic tel);
    @(negedge clk);
    fi.is_special_command = is_cmd;
    fi.set_speed          = speed;
    fi.special_command    = cmd;
    fi.crc_valid          = crc;
    fi.telemetry_bit      = tel;
    fi.frame_strobe       = 1'b1;
    @(negedge clk);
    fi.frame_strobe       = 1'b0;
  endtask

  task automatic send_cmd(input logic [5:0] cmd, input int n);
    for (int i = 0; i < n; i++) send(1'b1, 11'd0, cmd, 1'b1, 1'b0);
  endtask

  task automatic send_thr(input logic [10:0] speed);
    send(1'b0, speed, 6'd0, 1'b1, 1'b0);
  endtask

  initial begin
    reset_n               = 1'b0;
    fi.frame_strobe       = 1'b0;
    fi.set_speed          = '0;
    fi.special_command    = '0;
    fi.is_special_command = 1'b0;
    fi.crc_valid          = 1'b0;
    fi.telemetry_bit      = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_throttle", 32'(throttle), 0);
    check("rst_tvalid", 32'(throttle_valid), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_failsafe", 32'(failsafe), 0);
    check("rst_direction", 32'(direction), 0);
    check("rst_cmd_out", 32'(cmd_out), 0);
    check("rst_cmd_strobe", 32'(cmd_strobe), 0);
    check("rst_telem", 32'(telemetry_req), 0);
    check("rst_crc_cnt", 32'(crc_err_count), 0);
    reset_n = 1'b1;

    // Settings command repeat rules while disarmed
    send_cmd(6'd21, 5);
    check("c21x5_strobe", 32'(cmd_strobe), 0);
    check("c21x5_dir", 32'(direction), 0);
    send_cmd(6'd21, 1);
    check("c21x6_strobe", 32'(cmd_strobe), 1);
    check("c21x6_cmd_out", 32'(cmd_out), 21);
    check("c21x6_dir", 32'(direction), 1);
    send_cmd(6'd21, 1);
    check("c21x7_strobe", 32'(cmd_strobe), 0);
    send_cmd(6'd21, 4);
    send_cmd(6'd20, 5);
    check("c20x5_strobe", 32'(cmd_strobe), 0);
    check("c20x5_dir", 32'(direction), 1);
    send_cmd(6'd20, 1);
    check("c20x6_strobe", 32'(cmd_strobe), 1);
    check("c20x6_cmd_out", 32'(cmd_out), 20);
    check("c20x6_dir", 32'(direction), 0);
    send_cmd(6'd6, 6);
    check("c6x6_strobe", 32'(cmd_strobe), 0);
    check("c6x6_cmd_out", 32'(cmd_out), 20);
    send_cmd(6'd8, 6);
    check("c8x6_strobe", 32'(cmd_strobe), 1);
    check("c8x6_cmd_out", 32'(cmd_out), 8);
    check("c8x6_dir", 32'(direction), 1);
    send_cmd(6'd3, 1);
    check("beep3_strobe", 32'(cmd_strobe), 1);
    check("beep3_cmd_out", 32'(cmd_out), 3);

    // Arming interrupted by a throttle frame, then a full arm sequence
    send_cmd(6'd0, 4);
    send_thr(11'd1000);
    check("interrupt_armed", 32'(armed), 0);
    check("interrupt_throttle", 32'(throttle), 0);
    send_cmd(6'd0, 9);
    check("arm9_armed", 32'(armed), 0);
    send_cmd(6'd0, 1);
    check("arm10_armed", 32'(armed), 1);
    check("arm10_tvalid", 32'(throttle_valid), 1);
    check("arm10_throttle", 32'(throttle), 0);
    check("arm10_failsafe", 32'(failsafe), 0);

    // Throttle hand-off, telemetry and bad-CRC frame
    send(1'b0, 11'd1500, 6'd0, 1'b1, 1'b1);
    check("thr1500", 32'(throttle), 1500);
    check("thr1500_tvalid", 32'(throttle_valid), 1);
    check("thr1500_telem", 32'(telemetry_req), 1);
    send(1'b0, 11'd200, 6'd0, 1'b0, 1'b1);
    check("badcrc_throttle", 32'(throttle), 1500);
    check("badcrc_telem", 32'(telemetry_req), 0);
    check("badcrc_cnt", 32'(crc_err_count), CRC_EN ? 1 : 0);

    // Beep while spinning is suppressed until throttle is back at zero
    send_thr(11'd800);
    check("thr800", 32'(throttle), 800);
    send_cmd(6'd1, 1);
    check("beep_spin_throttle", 32'(throttle), 0);
    check("beep_spin_strobe", 32'(cmd_strobe), 0);
    check("beep_spin_cmd_out", 32'(cmd_out), 3);
    send_cmd(6'd1, 1);
    check("beep_idle_strobe", 32'(cmd_strobe), 1);
    check("beep_idle_cmd_out", 32'(cmd_out), 1);

    // Failsafe exactly TIMEOUT_CYCLES clocks after the last good frame
    @(negedge clk);
    check("strobe_pulse_end", 32'(cmd_strobe), 0);
    repeat (48) @(negedge clk);
    check("to49_failsafe", 32'(failsafe), 0);
    check("to49_armed", 32'(armed), 1);
    @(negedge clk);
    check("to50_failsafe", 32'(failsafe), 1);
    check("to50_armed", 32'(armed), 0);
    check("to50_tvalid", 32'(throttle_valid), 0);
    check("to50_throttle", 32'(throttle), 0);
    check("to50_dir_kept", 32'(direction), 1);
    send_thr(11'd700);
    check("fs_thr_failsafe", 32'(failsafe), 1);
    check("fs_thr_throttle", 32'(throttle), 0);

    // Recovery: first command-0 counts as one arming frame
    send_cmd(6'd0, 1);
    check("fs_exit_failsafe", 32'(failsafe), 0);
    check("fs_exit_armed", 32'(armed), 0);
    send_cmd(6'd0, 8);
    check("rearm9_armed", 32'(armed), 0);
    send_cmd(6'd0, 1);
    check("rearm10_armed", 32'(armed), 1);

    // Good frame on the expiry cycle keeps ARMED
    repeat (48) @(negedge clk);
    send_thr(11'd600);
    check("race_armed", 32'(armed), 1);
    check("race_failsafe", 32'(failsafe), 0);
    check("race_throttle", 32'(throttle), 600);

    // Asynchronous reset in ARMED
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_throttle", 32'(throttle), 0);
    check("arst_tvalid", 32'(throttle_valid), 0);
    check("arst_armed", 32'(armed), 0);
    check("arst_direction", 32'(direction), 0);
    check("arst_cmd_out", 32'(cmd_out), 0);
    check("arst_crc_cnt", 32'(crc_err_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Bad-CRC command-0 frames: never arm, counter saturates when enabled
    for (int i = 0; i < 254; i++) send(1'b1, 11'd0, 6'd0, 1'b0, 1'b0);
    check("crc254", 32'(crc_err_count), CRC_EN ? 254 : 0);
    send(1'b1, 11'd0, 6'd0, 1'b0, 1'b0);
    check("crc255", 32'(crc_err_count), CRC_EN ? 255 : 0);
    for (int i = 0; i < 45; i++) send(1'b1, 11'd0, 6'd0, 1'b0, 1'b0);
    check("crc300", 32'(crc_err_count), CRC_EN ? 255 : 0);
    check("crc300_armed", 32'(armed), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dshot_command_controller.md
Name: dshot_command_controller

Overview:
- Sequences the DShot receive datapath output into motor-side control: arming, throttle hand-off, failsafe timeout and special-command execution.
- Consumes one decoded frame per frame_strobe from the DShot input/processing stage.
- Drives throttle, direction and command strobes to the downstream motor output stage.
- Special commands are gated by DShot repeat rules.

Parameters:
- CLK_HZ, 16000000, system clock frequency; documentation only, timing is set by the cycle-count parameters.
- TIMEOUT_CYCLES, 1600000, clocks without a good frame before failsafe (100 ms at 16 MHz).
- ARM_FRAMES, 10, consecutive good command-0 frames required to arm.
- CMD_REPEAT, 6, consecutive identical good frames required for settings commands 7..21.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_strobe  in  1  one-clk pulse when a new frame is decoded
- set_speed  in  11  decoded throttle, 0..1999
- special_command  in  6  decoded command number
- is_special_command  in  1  frame is a command (0..47), not a throttle
- crc_valid  in  1  frame CRC correct
- telemetry_bit  in  1  frame telemetry request bit
- throttle  out  11  throttle to output stage
- throttle_valid  out  1  high when ARMED; throttle is meaningful
- armed  out  1  state == ARMED
- failsafe  out  1  state == FAILSAFE
- direction  out  1  0 = normal, 1 = reversed
- cmd_out  out  6  last executed command number
- cmd_strobe  out  1  one-clk pulse when a command executes
- telemetry_req  out  1  one-clk pulse per good frame with telemetry_bit = 1
- crc_err_count  out  8  saturating count of bad-CRC frames

Behaviour:
- Good frame: frame_strobe && crc_valid. Bad frames are ignored except by the optional counter; they do not reload the timeout.
- Reset values: all outputs 0, state DISARMED, all counters 0.
- States:
  - DISARMED: throttle 0. Each good command-0 frame increments arm_cnt; any other good frame clears it. On reaching ARM_FRAMES -> ARMED on the next clk.
  - ARMED:
    - Good throttle frame: throttle <= set_speed, registered, 1 clk after strobe.
    - Good command frame: throttle <= 0.
    - Timeout counter reloads on every good frame. Expiry with no good frame -> FAILSAFE.
  - FAILSAFE: throttle 0, throttle_valid 0. A good command-0 frame -> DISARMED with arm_cnt = 1, so a full rearm is required.
- Simultaneous events: a good frame in the timeout-expiry cycle wins; timer reloads and state holds.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). Counts only in ARMED; cleared on entry to ARMED.
- Command execution applies in DISARMED, and in ARMED only when the previous throttle was 0:
  - Commands 1..5 (beeps): cmd_strobe on the first good frame.
  - Commands 7..21: rep_cnt increments on identical consecutive good frames. cmd_strobe fires exactly once, when rep_cnt reaches CMD_REPEAT. Further repeats do not re-strobe until a different frame arrives. Any different good frame resets rep_cnt to 1 for the new command.
  - Commands 0, 6 and 22..47: no strobe.
- Direction updates with the strobe:
  - 7 and 20 -> direction 0.
  - 8 and 21 -> direction 1.
- cmd_out holds the last strobed command.
- Latency: all outputs are registered, 1 clk after frame_strobe.
- reset_n asserted mid-operation: immediate return to reset values, direction included.

Optional Feature:
- Macro: DSHOT_CRC_ERR_COUNT_EN.
- Defined: crc_err_count increments on each frame_strobe with crc_valid=0 and saturates at 255; cleared only by reset.
- Undefined: crc_err_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- 10 good command-0 frames from reset -> armed=1 one clk after the 10th strobe. A throttle frame of 1000 at the 5th frame instead -> arm_cnt cleared, remains DISARMED.
- Armed, good throttle frame 1500 -> throttle=1500, throttle_valid=1, 1 clk after strobe. Next frame has bad CRC -> throttle stays 1500.
- Armed, no frames for 1600000 clks -> failsafe=1, throttle=0. Then 10 good command-0 frames -> DISARMED, then ARMED again.
- Disarmed, 6 good command-21 frames -> single cmd_strobe with cmd_out=21, direction=1. Command 21 x5 then command 20 x6 -> single strobe for 20, direction=0.
- Armed with throttle 800, command-1 frame -> throttle=0, no strobe. Second command-1 frame -> cmd_strobe, cmd_out=1.
- With DSHOT_CRC_ERR_COUNT_EN, 300 bad-CRC strobes -> crc_err_count=255. Without the macro -> 0. reset_n pulse mid-ARMED -> all outputs 0 asynchronously.
